regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Drives the regfile write port (reg_we/rd/rd_value) of the RV32I core, arbitrating between two sources:
  - the single-cycle ALU result;
  - results from long-latency units (load/mul), buffered in a small FIFO.
- Keeps a per-register pending scoreboard and raises stall for RAW/WAW hazards against outstanding long-latency results.

Parameters:
- XLEN, 32, data width
- FIFO_DEPTH, 4, long-result buffer entries (power of two, >=2)

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination
- alu_value  in  XLEN  ALU result
- long_issue  in  1  long-latency op issued this cycle (sets scoreboard)
- long_issue_rd  in  5  destination of issued op
- long_valid  in  1  long result offered
- long_ready  out  1  long result accepted when valid&ready
- long_rd  in  5  long result destination
- long_value  in  XLEN  long result data
- chk_rs1  in  5  decoding instruction source 1
- chk_rs2  in  5  decoding instruction source 2
- chk_rd  in  5  decoding instruction destination
- stall  out  1  hazard on chk_* against pending registers
- reg_we  out  1  regfile write enable
- rd  out  5  regfile write address
- rd_value  out  XLEN  regfile write data

Behaviour:
- Write-port outputs are combinational from the current inputs and the FIFO head. The regfile captures the write at the same posedge.
- Write priority each cycle:
  1. ALU write when alu_valid and alu_rd!=0.
  2. Otherwise the FIFO head, if the FIFO is non-empty; dequeue at this edge.
  3. Otherwise a direct long write when long_valid and the FIFO is empty (bypass, zero latency).
  4. Otherwise reg_we=0.
- Long handshake:
  - long_ready = !full && !rst.
  - An accepted long result not written directly this cycle is enqueued.
  - Enqueue and dequeue in the same cycle keep the count unchanged.
  - A long result with long_rd==0 is accepted and discarded. It is never enqueued or written.
- rd==0 is never written: reg_we=0 for any x0 write. rd/rd_value are don't-care when reg_we=0.
- FIFO is in-order. Entries are {rd, value}. Count range is 0..FIFO_DEPTH and pointers wrap modulo FIFO_DEPTH.
- Scoreboard: pend[31:1], with pend[0] hardwired 0.
  - Set when long_issue and long_issue_rd!=0.
  - Cleared when a long result (FIFO head or direct) for that rd is written via reg_we, or when a long result with that rd is discarded.
  - If set and clear for the same register coincide, set wins.
  - ALU writes never clear pend.
- stall = pend[chk_rs1] | pend[chk_rs2] | pend[chk_rd] | (long_issue && full). The stall is combinational.
- The issuing pipeline must not long_issue to a register already pending; stall guarantees this.
- Reset:
  - FIFO emptied and pend cleared.
  - long_ready=0, reg_we=0, and stall=0 while rst is high.
  - Results in flight at reset are lost.

Decomposition:
- Package rv32i_wb_pkg: XLEN, REG_ADDR_W=5, wb_entry_t {logic [4:0] rd; logic [XLEN-1:0] value;}.
- Sub-module wb_fifo: a synchronous FIFO of wb_entry_t with push/pop/full/empty and simultaneous push/pop support. It is instantiated once.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_value=0x1234 -> same-cycle reg_we=1, rd=5, rd_value=0x1234. Next cycle, the regfile reads 0x1234.
- long_issue rd=7, then chk_rs1=7 -> stall=1. Then long_valid, long_rd=7, long_value=0xCAFE with the FIFO empty and no ALU write -> direct write the same cycle, and stall drops the next cycle.
- alu_valid (rd=3) and long_valid (rd=9, 0xBEEF) together -> ALU writes x3 and x9 is enqueued. Next cycle with no ALU write, reg_we=1, rd=9, rd_value=0xBEEF, and pend[9] clears.
- ALU busy every cycle while 4 long results arrive -> long_ready falls to 0 after 4 accepts and long_issue gives stall=1. When ALU goes idle, the 4 results drain in order over 4 cycles.
- alu_rd=0 or long_rd=0 -> reg_we=0, nothing enqueued, and pend unchanged.
- Assert rst with 2 entries queued and pend[4] set -> the next cycle shows empty, long_ready=1, stall=0, and no write of the queued entries.

Source files
------------

// File: rtl/rv32i_wb_pkg.sv
// Shared types for the RV32I writeback arbiter: data width and the buffered
// long-latency result entry.
package rv32i_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       value;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO of writeback entries; a push and a pop in the
// same cycle leave the occupancy unchanged.
module wb_fifo
    import rv32i_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    wb_entry_t     mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: ALU results first, then buffered long-latency
// results, then a zero-latency long bypass; tracks pending long destinations.
module regfile_wb_arbiter
    import rv32i_wb_pkg::*;
#(
    parameter int XLEN       = rv32i_wb_pkg::XLEN,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_value,
    input  logic            long_issue,
    input  logic [4:0]      long_issue_rd,
    input  logic            long_valid,
    output logic            long_ready,
    input  logic [4:0]      long_rd,
    input  logic [XLEN-1:0] long_value,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    input  logic [4:0]      chk_rd,
    output logic            stall,
    output logic            reg_we,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_value
);

    // Long results use valid/ready: a result transfers on a cycle where both
    // long_valid and long_ready are high; long_value/long_rd must hold until then.

    wb_entry_t   head;
    wb_entry_t   push_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;

    logic        alu_wr;
    logic        head_wr;
    logic        bypass_wr;
    logic        long_acc;
    logic [31:1] pend_q;
    logic [31:0] pend;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;

    assign pend = {pend_q, 1'b0};

    always_comb begin
        long_ready = !fifo_full && !rst;
        long_acc   = long_valid && long_ready;
        alu_wr     = !rst && alu_valid && (alu_rd != 5'd0);
        head_wr    = !rst && !alu_wr && !fifo_empty;
        bypass_wr  = !rst && !alu_wr && fifo_empty && long_valid && (long_rd != 5'd0);
        // Discarded x0 results and bypassed results never enter the buffer.
        fifo_push  = long_acc && (long_rd != 5'd0) && !bypass_wr;
        fifo_pop   = head_wr;
        push_data  = '{rd: long_rd, value: long_value};

        reg_we   = alu_wr || head_wr || bypass_wr;
        rd       = 5'd0;
        rd_value = '0;
        if (alu_wr) begin
            rd       = alu_rd;
            rd_value = alu_value;
        end else if (head_wr) begin
            rd       = head.rd;
            rd_value = head.value;
        end else if (bypass_wr) begin
            rd       = long_rd;
            rd_value = long_value;
        end

        set_vec = '0;
        if (long_issue && (long_issue_rd != 5'd0)) set_vec = 32'd1 << long_issue_rd;
        clr_vec = '0;
        if (head_wr || bypass_wr) clr_vec = 32'd1 << rd;

        stall = !rst && (pend[chk_rs1] || pend[chk_rs2] || pend[chk_rd] ||
                         (long_issue && fifo_full));
    end

    // A coincident set on the same register overrides the clear.
    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= (pend_q & ~clr_vec[31:1]) | set_vec[31:1];
    end

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int EW    = 5 + XLEN;

    logic            clk;
    logic            rst;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_value;
    logic            long_issue;
    logic [4:0]      long_issue_rd;
    logic            long_valid;
    logic            long_ready;
    logic [4:0]      long_rd;
    logic [XLEN-1:0] long_value;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic [4:0]      chk_rd;
    logic            stall;
    logic            reg_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_value;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [EW-1:0]   exp_q[$];
    bit   [31:0]     m_pend;
    logic [XLEN-1:0] rf [32];

    logic            exp_we;
    logic [4:0]      exp_rd;
    logic [XLEN-1:0] exp_val;
    logic            exp_ready;
    logic            exp_stall;

    regfile_wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_value     (alu_value),
        .long_issue    (long_issue),
        .long_issue_rd (long_issue_rd),
        .long_valid    (long_valid),
        .long_ready    (long_ready),
        .long_rd       (long_rd),
        .long_value    (long_value),
        .chk_rs1       (chk_rs1),
        .chk_rs2       (chk_rs2),
        .chk_rd        (chk_rd),
        .stall         (stall),
        .reg_we        (reg_we),
        .rd            (rd),
        .rd_value      (rd_value)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        alu_valid     = 1'b0;
        alu_rd        = 5'd0;
        alu_value     = '0;
        long_issue    = 1'b0;
        long_issue_rd = 5'd0;
        long_valid    = 1'b0;
        long_rd       = 5'd0;
        long_value    = '0;
        chk_rs1       = 5'd0;
        chk_rs2       = 5'd0;
        chk_rd        = 5'd0;
    endtask

    // Expected outputs from the current inputs and the model's queue/pending set.
    task automatic model_eval();
        logic alu_ok;
        alu_ok    = alu_valid && alu_rd != 0;
        exp_ready = !rst && exp_q.size() < DEPTH;
        exp_we    = 1'b0;
        exp_rd    = 5'd0;
        exp_val   = '0;
        if (!rst) begin
            if (alu_ok) begin
                exp_we = 1'b1; exp_rd = alu_rd; exp_val = alu_value;
            end else if (exp_q.size() > 0) begin
                exp_we = 1'b1; exp_rd = exp_q[0][EW-1:XLEN]; exp_val = exp_q[0][XLEN-1:0];
            end else if (long_valid && long_rd != 0) begin
                exp_we = 1'b1; exp_rd = long_rd; exp_val = long_value;
            end
        end
        exp_stall = !rst && (m_pend[chk_rs1] || m_pend[chk_rs2] || m_pend[chk_rd] ||
                             (long_issue && exp_q.size() == DEPTH));
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_update();
        bit alu_ok, accepted, direct;
        if (rst) begin
            exp_q.delete();
            m_pend = '0;
            return;
        end
        alu_ok   = alu_valid && alu_rd != 0;
        accepted = long_valid && exp_q.size() < DEPTH;
        direct   = 1'b0;
        if (!alu_ok && exp_q.size() > 0) begin
            m_pend[exp_q[0][EW-1:XLEN]] = 1'b0;
            void'(exp_q.pop_front());
        end else if (!alu_ok && long_valid && long_rd != 0) begin
            m_pend[long_rd] = 1'b0;
            direct = 1'b1;
        end
        if (accepted && long_rd != 0 && !direct) exp_q.push_back({long_rd, long_value});
        if (long_issue && long_issue_rd != 0) m_pend[long_issue_rd] = 1'b1;
        m_pend[0] = 1'b0;
    endtask

    // Regfile capture of the write port, model step, then one full cycle.
    task automatic tick();
        if (reg_we) rf[rd] = rd_value;
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd2; long_valid = 1'b1; long_rd = 5'd3;
        @(negedge clk);
        tick();
        #1;
        n_checks++;
        if (reg_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", reg_we); end
        n_checks++;
        if (long_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", long_ready); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        tick();
        rst = 1'b0;
        drive_idle();
        #1;
        n_checks++;
        if (long_ready !== 1'b1 || reg_we !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: ready=%b we=%b stall=%b want 1 0 0", long_ready, reg_we, stall);
        end
        tick();
    endtask

    task automatic test_alu_write();
        drive_idle();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_value = 32'h1234;
        #1;
        n_checks++;
        if (reg_we !== 1'b1 || rd !== 5'd5 || rd_value !== 32'h1234) begin
            n_fail++;
            $display("FAIL alu_write: we=%b rd=%0d val=%h want 1 5 1234", reg_we, rd, rd_value);
        end
        tick();
        drive_idle();
        #1;
        n_checks++;
        if (rf[5] !== 32'h1234) begin n_fail++; $display("FAIL alu_rf_read: got %h want 1234", rf[5]); end
        tick();
    endtask

    task automatic test_direct_long();
        drive_idle();
        long_issue = 1'b1; long_issue_rd = 5'd7;
        tick();
        drive_idle();
        chk_rs1 = 5'd7;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b want 1", stall); end
        long_valid = 1'b1; long_rd = 5'd7; long_value = 32'hCAFE;
        #1;
        n_checks++;
        if (reg_we !== 1'b1 || rd !== 5'd7 || rd_value !== 32'hCAFE || long_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL direct_write: we=%b rd=%0d val=%h ready=%b want 1 7 cafe 1", reg_we, rd, rd_value, long_ready);
        end
        tick();
        drive_idle();
        chk_rs1 = 5'd7;
        #1;
        n_checks++;
        if (stall !== 1'b0 || reg_we !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_clear: stall=%b we=%b want 0 0", stall, reg_we);
        end
        tick();
    endtask

    task automatic test_alu_and_long();
        drive_idle();
        long_issue = 1'b1; long_issue_rd = 5'd9;
        tick();
        drive_idle();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_value = 32'h3333;
        long_valid = 1'b1; long_rd = 5'd9; long_value = 32'hBEEF;
        #1;
        n_checks++;
        if (reg_we !== 1'b1 || rd !== 5'd3 || rd_value !== 32'h3333) begin
            n_fail++;
            $display("FAIL alu_over_long: we=%b rd=%0d val=%h want 1 3 3333", reg_we, rd, rd_value);
        end
        tick();
        drive_idle();
        chk_rs2 = 5'd9;
        #1;
        n_checks++;
        if (reg_we !== 1'b1 || rd !== 5'd9 || rd_value !== 32'hBEEF || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL queued_write: we=%b rd=%0d val=%h stall=%b want 1 9 beef 1", reg_we, rd, rd_value, stall);
        end
        tick();
        drive_idle();
        chk_rs2 = 5'd9;
        #1;
        n_checks++;
        if (stall !== 1'b0 || reg_we !== 1'b0) begin
            n_fail++;
            $display("FAIL queued_clear: stall=%b we=%b want 0 0", stall, reg_we);
        end
        tick();
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < DEPTH; i++) begin
            drive_idle();
            long_issue = 1'b1; long_issue_rd = 5'(10 + i);
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive_idle();
            alu_valid = 1'b1; alu_rd = 5'd1; alu_value = 32'(i);
            long_valid = 1'b1; long_rd = 5'(10 + i); long_value = 32'hA000 + 32'(i);
            #1;
            n_checks++;
            if (long_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b want 1", i, long_ready); end
            tick();
        end
        drive_idle();
        alu_valid = 1'b1; alu_rd = 5'd1; long_valid = 1'b1; long_rd = 5'd20;
        long_issue = 1'b1; long_issue_rd = 5'd21;
        #1;
        n_checks++;
        if (long_ready !== 1'b0 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL full_backpressure: ready=%b stall=%b want 0 1", long_ready, stall);
        end
        long_issue = 1'b0; long_valid = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive_idle();
            #1;
            n_checks++;
            if (reg_we !== 1'b1 || rd !== 5'(10 + i) || rd_value !== 32'hA000 + 32'(i)) begin
                n_fail++;
                $display("FAIL drain[%0d]: we=%b rd=%0d val=%h want 1 %0d %h", i, reg_we, rd, rd_value, 10 + i, 32'hA000 + i);
            end
            tick();
        end
    endtask

    task automatic test_x0();
        drive_idle();
        long_issue = 1'b1; long_issue_rd = 5'd6;
        tick();
        drive_idle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_value = 32'h1;
        #1;
        n_checks++;
        if (reg_we !== 1'b0) begin n_fail++; $display("FAIL alu_x0: we=%b want 0", reg_we); end
        alu_valid = 1'b0;
        long_valid = 1'b1; long_rd = 5'd0; long_value = 32'h2;
        #1;
        n_checks++;
        if (reg_we !== 1'b0 || long_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL long_x0: we=%b ready=%b want 0 1", reg_we, long_ready);
        end
        tick();
        drive_idle();
        chk_rd = 5'd6;
        #1;
        n_checks++;
        if (reg_we !== 1'b0 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_no_side_effect: we=%b stall=%b want 0 1", reg_we, stall);
        end
        long_valid = 1'b1; long_rd = 5'd6; long_value = 32'h6;
        tick();
    endtask

    task automatic test_reset_flush();
        drive_idle();
        long_issue = 1'b1; long_issue_rd = 5'd4;
        tick();
        for (int i = 0; i < 2; i++) begin
            drive_idle();
            alu_valid = 1'b1; alu_rd = 5'd1;
            long_valid = 1'b1; long_rd = 5'(20 + i); long_value = 32'(i);
            tick();
        end
        drive_idle();
        rst = 1'b1; chk_rs1 = 5'd4;
        #1;
        n_checks++;
        if (reg_we !== 1'b0 || long_ready !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL in_reset: we=%b ready=%b stall=%b want 0 0 0", reg_we, long_ready, stall);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (reg_we !== 1'b0 || long_ready !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL after_flush: we=%b ready=%b stall=%b want 0 1 0", reg_we, long_ready, stall);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive_idle();
            alu_valid     = ($urandom_range(0, 99) < 45);
            alu_rd        = 5'($urandom_range(0, 31));
            alu_value     = $urandom;
            long_issue_rd = 5'($urandom_range(0, 31));
            long_issue    = ($urandom_range(0, 99) < 30) && !m_pend[long_issue_rd];
            long_valid    = ($urandom_range(0, 99) < 50);
            long_rd       = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            long_value    = $urandom;
            chk_rs1       = 5'($urandom_range(0, 31));
            chk_rs2       = 5'($urandom_range(0, 31));
            chk_rd        = 5'($urandom_range(0, 31));
            #1;
            model_eval();
            n_checks++;
            if (reg_we !== exp_we || long_ready !== exp_ready || stall !== exp_stall ||
                (exp_we && (rd !== exp_rd || rd_value !== exp_val))) begin
                n_fail++;
                $display("FAIL random[%0d]: we=%b rd=%0d val=%h ready=%b stall=%b want %b %0d %h %b %b",
                         c, reg_we, rd, rd_value, long_ready, stall,
                         exp_we, exp_rd, exp_val, exp_ready, exp_stall);
            end
            tick();
        end
    endtask

    initial begin
        exp_q.delete();
        m_pend = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_alu_write();
        test_direct_long();
        test_alu_and_long();
        test_fifo_full();
        test_x0();
        test_reset_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
